csr_rmw_unit: RTL and testbench

Parametrised CSR read-modify-write unit for the execute stage. It replaces the purely combinational CSR ALU with a stateful block that owns a small CSR array and executes CSRRW/CSRRS/CSRRC in one accepted transaction. Each transaction returns the old value to the writeback path through a valid/ready handshake. It applies per-CSR write masks, flags out-of-range addresses, and optionally hosts a free-running cycle counter CSR.

---
 rtl/csr_rmw_unit_pkg.sv | 28 ++
 rtl/csr_rmw_calc.sv | 38 +++
 rtl/csr_rmw_unit.sv | 133 +++++++++++++
 tb/tb_csr_rmw_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_rmw_unit_pkg.sv
// csr_rmw_unit_pkg
// Shared types and width constants for the CSR read-modify-write unit.
//   csrop_t   : CSR operation encoding (RW / RS / RC)
//   csr_req_t : request bundle {op, addr, src, nowr} as carried by the pipe
//   u64       : common 64-bit data type
//   CSR_*     : default widths/sizes used as parameter defaults
package csr_rmw_unit_pkg;

  localparam int CSR_XLEN = 64;
  localparam int CSR_NCSR = 8;
  localparam int CSR_AW   = 4;

  typedef logic [63:0] u64;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csrop_t;

  typedef struct packed {
    csrop_t                 op;
    logic [CSR_AW-1:0]      addr;
    u64                     src;
    logic                   nowr;
  } csr_req_t;

endpackage

// File: rtl/csr_rmw_calc.sv
// csr_rmw_calc
// Combinational CSR operation datapath: computes the operation result from
// the current CSR value and the operand, then merges it with the old value
// under the per-CSR write mask so that read-only bits keep their contents.
// Ports:
//   op    in  csrop_t  operation (RW / RS / RC)
//   old   in  XLEN     current CSR value
//   src   in  XLEN     operand
//   mask  in  XLEN     write mask, 1 = writable bit
//   wdata out XLEN     value to write back
module csr_rmw_calc
  import csr_rmw_unit_pkg::*;
#(
  parameter int XLEN = CSR_XLEN
) (
  input  csrop_t            op,
  input  logic [XLEN-1:0]   old,
  input  logic [XLEN-1:0]   src,
  input  logic [XLEN-1:0]   mask,
  output logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] result_s;

  // Operation result before masking; an unknown encoding leaves the CSR as is.
  always_comb begin
    result_s = old;
    case (op)
      CSR_RW:  result_s = src;
      CSR_RS:  result_s = old | src;
      CSR_RC:  result_s = old & ~src;
      default: result_s = old;
    endcase
  end

  assign wdata = (old & ~mask) | (result_s & mask);

endmodule

// File: rtl/csr_rmw_unit.sv
// csr_rmw_unit
// Stateful CSR read-modify-write unit. Owns NCSR CSRs, executes one
// CSRRW/CSRRS/CSRRC per accepted request and returns the pre-operation value
// through a single-entry output register with valid/ready handshaking.
// Out-of-range addresses return 0 with out_err set and modify nothing.
// Optional feature macro: CSR_CYCLE_EN -- when defined, CSR NCSR-1 is a
// free-running cycle counter (a write in the same cycle overrides the
// increment).
// Ports:
//   clk        in   clock, rising edge
//   reset_n    in   synchronous active-low reset
//   in_valid   in   request present
//   in_ready   out  request can be accepted this cycle
//   in_op      in   csrop_t operation
//   in_addr    in   AW-bit CSR index
//   in_src     in   XLEN operand
//   in_nowr    in   suppress the write
//   out_valid  out  result held
//   out_ready  in   downstream consumes result
//   out_old    out  CSR value before the operation
//   out_err    out  address was out of range
module csr_rmw_unit
  import csr_rmw_unit_pkg::*;
#(
  parameter int                        XLEN  = CSR_XLEN,
  parameter int                        NCSR  = CSR_NCSR,
  parameter int                        AW    = CSR_AW,
  parameter logic [NCSR-1:0][XLEN-1:0] WMASK = '1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  csrop_t          in_op,
  input  logic [AW-1:0]   in_addr,
  input  logic [XLEN-1:0] in_src,
  input  logic            in_nowr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_old,
  output logic            out_err
);

  // One extra bit so the range check also works when 2**AW == NCSR.
  localparam logic [AW:0] NCSR_W = (AW+1)'(NCSR);

  logic            accept_s;
  logic            err_s;
  logic            wr_en_s;
  logic [XLEN-1:0] old_s;
  logic [XLEN-1:0] mask_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] csr_r     [NCSR];
  logic [XLEN-1:0] csr_nxt_s [NCSR];
  logic            out_valid_r;
  logic            out_err_r;
  logic [XLEN-1:0] out_old_r;

  // A held result blocks new requests unless it drains in the same cycle.
  assign in_ready = !out_valid_r | out_ready;
  assign accept_s = in_valid & in_ready;
  assign err_s    = ({1'b0, in_addr} >= NCSR_W);
  assign wr_en_s  = accept_s & !in_nowr & !err_s;

  // Read mux over the array and mask table; no match (out of range) yields 0.
  always_comb begin
    old_s  = '0;
    mask_s = '0;
    for (int i = 0; i < NCSR; i++) begin
      old_s  = (in_addr == AW'(i)) ? csr_r[i] : old_s;
      mask_s = (in_addr == AW'(i)) ? WMASK[i] : mask_s;
    end
  end

  csr_rmw_calc #(
    .XLEN (XLEN)
  ) u_calc (
    .op    (in_op),
    .old   (old_s),
    .src   (in_src),
    .mask  (mask_s),
    .wdata (wdata_s)
  );

  // Next-state of every CSR; the counter CSR increments unless written.
  always_comb begin
    for (int i = 0; i < NCSR; i++) begin
      csr_nxt_s[i] = (wr_en_s && (in_addr == AW'(i))) ? wdata_s : csr_r[i];
    end
`ifdef CSR_CYCLE_EN
    if (wr_en_s && (in_addr == AW'(NCSR-1))) begin
      csr_nxt_s[NCSR-1] = wdata_s;
    end else begin
      csr_nxt_s[NCSR-1] = csr_r[NCSR-1] + XLEN'(1);
    end
`endif
  end

  // CSR array state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NCSR; i++) begin
        csr_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCSR; i++) begin
        csr_r[i] <= csr_nxt_s[i];
      end
    end
  end

  // Output register: loads on accept, empties when consumed without refill.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_r <= 1'b0;
      out_old_r   <= '0;
      out_err_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_old_r   <= old_s;
      out_err_r   <= err_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_old   = out_old_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// tb_csr_rmw_unit
// Self-checking bench for csr_rmw_unit: directed scenarios plus randomized
// traffic compared against a transaction-level model of the CSR array.
// Honours CSR_CYCLE_EN the same way the design does.
module tb_csr_rmw_unit;
  import csr_rmw_unit_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M3   = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] M5   = 64'hF0F0_0000_FFFF_0F0F;
  localparam logic [7:0][63:0] TB_WMASK = {ONES, ONES, M5, ONES, M3, ONES, ONES, ONES};

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  csrop_t      in_op;
  logic [3:0]  in_addr;
  logic [63:0] in_src;
  logic        in_nowr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_old;
  logic        out_err;

  // Reference model state
  logic [63:0] mem [8];
  logic [63:0] msk [8];
  logic        ov_m;
  logic [63:0] exp_old;
  logic        exp_err;

  int tests_run;
  int tests_failed;

  csr_rmw_unit #(
    .XLEN  (64),
    .NCSR  (8),
    .AW    (4),
    .WMASK (TB_WMASK)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_src    (in_src),
    .in_nowr   (in_nowr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_old   (out_old),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, predict, clock, then compare outputs.
  task automatic step(input logic v, input csrop_t op, input logic [3:0] a,
                      input logic [63:0] s, input logic nw, input logic ordy);
    logic        rdy;
    logic        acc;
    logic        er;
    logic        wr;
    logic [63:0] old;
    logic [63:0] nv;
    logic [63:0] m;
    logic [63:0] wd;
    in_valid  = v;
    in_op     = op;
    in_addr   = a;
    in_src    = s;
    in_nowr   = nw;
    out_ready = ordy;
    #1;
    rdy = !ov_m | ordy;
    check("in_ready", {63'd0, in_ready}, {63'd0, rdy});
    acc = v & rdy & reset_n;
    er  = (a >= 4'd8);
    old = er ? 64'd0 : mem[a[2:0]];
    m   = er ? 64'd0 : msk[a[2:0]];
    if (op == CSR_RW)      nv = s;
    else if (op == CSR_RS) nv = old | s;
    else                   nv = old & ~s;
    wd = (old & ~m) | (nv & m);
    wr = acc & !nw & !er;
    @(posedge clk);
    if (!reset_n) begin
      ov_m = 1'b0;
      for (int i = 0; i < 8; i++) mem[i] = 64'd0;
    end else begin
      if (acc) begin
        ov_m    = 1'b1;
        exp_old = old;
        exp_err = er;
      end else if (ordy) begin
        ov_m = 1'b0;
      end
`ifdef CSR_CYCLE_EN
      if (!(wr && a == 4'd7)) mem[7] = mem[7] + 64'd1;
`endif
      if (wr) mem[a[2:0]] = wd;
    end
    @(negedge clk);
    check("out_valid", {63'd0, out_valid}, {63'd0, ov_m});
    if (ov_m) begin
      check("out_old", out_old, exp_old);
      check("out_err", {63'd0, out_err}, {63'd0, exp_err});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, CSR_RW, 4'd0, 64'd0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b1, CSR_RW, 4'd2, 64'h1111, 1'b0, 1'b1);
    step(1'b1, CSR_RW, 4'd7, 64'h2222, 1'b0, 1'b1);
    reset_n = 1'b1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_old", out_old, 64'd0);
    check("rst_err", {63'd0, out_err}, 64'd0);
  endtask

  initial begin
    logic [1:0] opr;
    tests_run    = 0;
    tests_failed = 0;
    ov_m         = 1'b0;
    exp_old      = 64'd0;
    exp_err      = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = 64'd0;
      msk[i] = TB_WMASK[i];
    end
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = CSR_RW;
    in_addr   = 4'd0;
    in_src    = 64'd0;
    in_nowr   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

`ifdef CSR_CYCLE_EN
    // Counter reads its cycle number after reset.
    idle(10);
    step(1'b1, CSR_RS, 4'd7, 64'd0, 1'b1, 1'b1);
    check("cyc10", out_old, 64'd10);
    step(1'b1, CSR_RW, 4'd7, 64'd100, 1'b0, 1'b1);
    idle(1);
    step(1'b1, CSR_RS, 4'd7, 64'd0, 1'b1, 1'b1);
    check("cyc_wr", out_old, 64'd101);
    do_reset();
`endif

    // Basic RW then non-writing RS
    step(1'b1, CSR_RW, 4'd2, 64'hDEAD, 1'b0, 1'b1);
    check("rw2_old", out_old, 64'd0);
    step(1'b1, CSR_RS, 4'd2, 64'd0, 1'b1, 1'b1);
    check("rs2_old", out_old, 64'hDEAD);
    step(1'b1, CSR_RS, 4'd2, 64'd0, 1'b1, 1'b1);
    check("rs2_keep", out_old, 64'hDEAD);

    // Write mask preserves read-only bits
    step(1'b1, CSR_RW, 4'd3, 64'hFFFF, 1'b0, 1'b1);
    step(1'b1, CSR_RS, 4'd3, 64'd0, 1'b1, 1'b1);
    check("mask3", out_old, 64'h00FF);

    // Back-to-back on one address
    step(1'b1, CSR_RW, 4'd1, 64'hF0, 1'b0, 1'b1);
    check("b2b_0", out_old, 64'd0);
    step(1'b1, CSR_RS, 4'd1, 64'h0F, 1'b0, 1'b1);
    check("b2b_1", out_old, 64'hF0);
    step(1'b1, CSR_RC, 4'd1, 64'h30, 1'b0, 1'b1);
    check("b2b_2", out_old, 64'hFF);
    step(1'b1, CSR_RS, 4'd1, 64'd0, 1'b1, 1'b1);
    check("b2b_fin", out_old, 64'hCF);

    // Out-of-range address
    step(1'b1, CSR_RW, 4'd8, 64'd5, 1'b0, 1'b1);
    check("err_flag", {63'd0, out_err}, 64'd1);
    check("err_old", out_old, 64'd0);
    for (int i = 0; i < 7; i++) step(1'b1, CSR_RS, 4'(i), 64'd0, 1'b1, 1'b1);

    // Backpressure: result held, new request stalls, then drains
    step(1'b1, CSR_RW, 4'd4, 64'h1234, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CSR_RW, 4'd4, 64'h5555, 1'b0, 1'b0);
      check("bp_ready", {63'd0, in_ready}, 64'd0);
      check("bp_hold", out_old, 64'd0);
    end
    step(1'b1, CSR_RW, 4'd4, 64'h5555, 1'b0, 1'b1);
    check("bp_drain", out_old, 64'h1234);
    step(1'b1, CSR_RS, 4'd4, 64'd0, 1'b1, 1'b1);
    check("bp_final", out_old, 64'h5555);

    // Reset mid-stream discards the held result and clears the array
    step(1'b1, CSR_RW, 4'd2, 64'hBEEF, 1'b0, 1'b0);
    do_reset();
    step(1'b1, CSR_RS, 4'd2, 64'd0, 1'b1, 1'b1);
    check("rst_arr", out_old, 64'd0);
`ifdef CSR_CYCLE_EN
    step(1'b1, CSR_RS, 4'd7, 64'd0, 1'b1, 1'b1);
    check("rst_cnt", out_old, 64'd1);
`endif

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      opr = 2'($urandom_range(2, 0));
      step(($urandom_range(3, 0) != 0),
           csrop_t'(opr),
           4'($urandom_range(9, 0)),
           {$urandom, $urandom},
           ($urandom_range(3, 0) == 0),
           ($urandom_range(3, 0) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
